// File: rtl/golden_nonce_reporter.sv
// Golden nonce reporter: queues winning nonces from the hashing core and
// serialises each one as a 5-byte UART frame: HDR_BYTE, then the nonce MSB first.
//
// Ports:
//   hash_clk         - single clock, rising edge
//   reset            - asynchronous, active-high reset
//   new_golden_nonce - strobe, golden_nonce valid this cycle
//   golden_nonce     - 32-bit winning nonce
//   flush            - new-work strobe, discards queued (not in-flight) nonces
//   tx_byte/tx_valid - registered byte offer to the UART transmitter
//   tx_ready         - transmitter accepts tx_byte this cycle
//   fifo_count       - queued nonces, excluding the frame in flight
//   overflow         - sticky, set when a nonce is dropped
//   drop_count       - saturating count of dropped nonces
module golden_nonce_reporter #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  HDR_BYTE = 8'hAA
) (
  input  logic                     hash_clk,
  input  logic                     reset,
  input  logic                     new_golden_nonce,
  input  logic [31:0]              golden_nonce,
  input  logic                     flush,
  output logic [7:0]               tx_byte,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StHdr  = 3'd1;
  localparam logic [2:0] StB3   = 3'd2;
  localparam logic [2:0] StB2   = 3'd3;
  localparam logic [2:0] StB1   = 3'd4;
  localparam logic [2:0] StB0   = 3'd5;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [2:0]    state_q, state_d;
  logic [31:0]   frame_q, frame_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_valid_q, tx_valid_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  logic hs;
  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic load;
  logic wr_en;
  logic drop;

  function automatic logic [7:0] byte_sel(input logic [2:0] st, input logic [31:0] fr);
    logic [7:0] b;
    case (st)
      StHdr:   b = HDR_BYTE;
      StB3:    b = fr[31:24];
      StB2:    b = fr[23:16];
      StB1:    b = fr[15:8];
      StB0:    b = fr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  always_comb begin
    hs         = tx_valid_q && tx_ready;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(DEPTH));
    push       = new_golden_nonce && !flush;
    // Flush wins over a load on the same edge: every queued entry is stale.
    load       = !flush && !fifo_empty &&
                 ((state_q == StIdle) || ((state_q == StB0) && hs));
    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    wr_en      = push && (!fifo_full || load);
    drop       = push && fifo_full && !load;
  end

  // FIFO bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (load)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_en, load})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    drop_d     = drop_q;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    frame_d = load ? mem[rd_ptr_q] : frame_q;
    case (state_q)
      StIdle:  if (load) state_d = StHdr;
      StHdr:   if (hs) state_d = StB3;
      StB3:    if (hs) state_d = StB2;
      StB2:    if (hs) state_d = StB1;
      StB1:    if (hs) state_d = StB0;
      StB0:    if (hs) state_d = load ? StHdr : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered. Leaving IDLE, the load edge only moves the FSM to
  // HDR; tx_valid rises one edge later. Without a handshake the current byte
  // is (re)offered, so it holds under backpressure.
  always_comb begin
    if (state_q == StIdle) begin
      tx_valid_d = 1'b0;
      tx_byte_d  = 8'h00;
    end else if (hs) begin
      tx_valid_d = (state_d != StIdle);
      tx_byte_d  = byte_sel(state_d, frame_d);
    end else begin
      tx_valid_d = 1'b1;
      tx_byte_d  = byte_sel(state_q, frame_q);
    end
  end

  always_ff @(posedge hash_clk) begin
    if (wr_en) mem[wr_ptr_q] <= golden_nonce;
  end

  always_ff @(posedge hash_clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= StIdle;
      frame_q    <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_valid   = tx_valid_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_reporter.sv
module tb_golden_nonce_reporter;

  logic        hash_clk = 1'b0;
  logic        reset;
  logic        new_golden_nonce;
  logic [31:0] golden_nonce;
  logic        flush;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] n [6];

  golden_nonce_reporter #(
    .DEPTH   (4),
    .HDR_BYTE(8'hAA)
  ) dut (
    .hash_clk        (hash_clk),
    .reset           (reset),
    .new_golden_nonce(new_golden_nonce),
    .golden_nonce    (golden_nonce),
    .flush           (flush),
    .tx_byte         (tx_byte),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .fifo_count      (fifo_count),
    .overflow        (overflow),
    .drop_count      (drop_count)
  );

  always #5 hash_clk = ~hash_clk;

  task automatic step();
    @(posedge hash_clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    new_golden_nonce = 1'b0;
    golden_nonce = '0;
    flush = 1'b0;
    tx_ready = 1'b0;
    #3;
    checks++;
    if ({tx_valid, tx_byte, fifo_count, overflow, drop_count} !== 20'h0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b byte=%h cnt=%0d ovf=%b drops=%0d, want all 0",
               tx_valid, tx_byte, fifo_count, overflow, drop_count);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] exp [4];
    exp = '{8'h12, 8'h34, 8'h56, 8'h78};
    tx_ready = 1'b1;
    new_golden_nonce = 1'b1;
    golden_nonce = 32'h12345678;
    step();
    new_golden_nonce = 1'b0;
    checks++;
    if (tx_valid !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL single_push: got valid=%b cnt=%0d, want valid=0 cnt=1", tx_valid, fifo_count);
    end
    step();
    checks++;
    if (tx_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL single_load: got valid=%b cnt=%0d, want valid=0 cnt=0", tx_valid, fifo_count);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'hAA) begin
      errors++;
      $display("FAIL single_hdr: got valid=%b byte=%h, want 1 aa", tx_valid, tx_byte);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp[i]) begin
        errors++;
        $display("FAIL single_byte%0d: got valid=%b byte=%h, want 1 %h", i, tx_valid, tx_byte,
                 exp[i]);
      end
    end
    step();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_end: got valid=%b, want 0", tx_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    apply_reset();
    tx_ready = 1'b0;
    new_golden_nonce = 1'b1;
    golden_nonce = 32'hDEADBEEF;
    step();
    new_golden_nonce = 1'b0;
    step();
    step();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid !== 1'b1 || tx_byte !== 8'hAA) bad++;
      step();
    end
    checks++;
    if (bad != 0 || tx_valid !== 1'b1 || tx_byte !== 8'hAA) begin
      errors++;
      $display("FAIL bp_hold: %0d stalled cycles off, now valid=%b byte=%h, want 1 aa",
               bad, tx_valid, tx_byte);
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp[i]) begin
        errors++;
        $display("FAIL bp_byte%0d: got valid=%b byte=%h, want 1 %h", i, tx_valid, tx_byte,
                 exp[i]);
      end
    end
    step();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got valid=%b, want 0", tx_valid);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] cap [25];
    logic [7:0] want;
    int got;
    int cyc;
    apply_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      new_golden_nonce = 1'b1;
      golden_nonce = n[i];
      step();
    end
    new_golden_nonce = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1 || drop_count !== 8'd1) begin
      errors++;
      $display("FAIL ovf_state: got cnt=%0d ovf=%b drops=%0d, want 4 1 1",
               fifo_count, overflow, drop_count);
    end
    tx_ready = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 25 && cyc < 60) begin
      if (tx_valid === 1'b1) begin
        cap[got] = tx_byte;
        got++;
      end
      step();
      cyc++;
    end
    checks++;
    if (got != 25 || cyc != 25) begin
      errors++;
      $display("FAIL ovf_b2b: got %0d bytes in %0d cycles, want 25 in 25", got, cyc);
    end
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 5; b++) begin
        want = (b == 0) ? 8'hAA : n[f][32-8*b +: 8];
        checks++;
        if (cap[f*5+b] !== want) begin
          errors++;
          $display("FAIL ovf_frame%0d_byte%0d: got %h, want %h", f, b, cap[f*5+b], want);
        end
      end
    end
    checks++;
    if (tx_valid !== 1'b0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL ovf_drained: got valid=%b cnt=%0d, want 0 0", tx_valid, fifo_count);
    end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] cap [25];
    int got;
    apply_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      new_golden_nonce = 1'b1;
      golden_nonce = n[i];
      step();
    end
    new_golden_nonce = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL full_fill: got cnt=%0d drops=%0d, want 4 0", fifo_count, drop_count);
    end
    tx_ready = 1'b1;
    // HDR shown now; four edges later B0 is shown and the next edge is the load.
    for (int i = 0; i < 4; i++) step();
    new_golden_nonce = 1'b1;
    golden_nonce = 32'hCAFEF00D;
    step();
    new_golden_nonce = 1'b0;
    checks++;
    if (fifo_count !== 3'd4 || drop_count !== 8'd0 || overflow !== 1'b0 ||
        tx_valid !== 1'b1 || tx_byte !== 8'hAA) begin
      errors++;
      $display("FAIL full_pushpop: got cnt=%0d drops=%0d ovf=%b valid=%b byte=%h, want 4 0 0 1 aa",
               fifo_count, drop_count, overflow, tx_valid, tx_byte);
    end
    got = 0;
    for (int c = 0; c < 60 && got < 25; c++) begin
      if (tx_valid === 1'b1) begin
        cap[got] = tx_byte;
        got++;
      end
      step();
    end
    checks++;
    if (got != 25 || cap[1] !== n[1][31:24] ||
        {cap[21], cap[22], cap[23], cap[24]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL full_order: got %0d bytes, second frame msb %h, last nonce %h, want 25 %h cafef00d",
               got, cap[1], {cap[21], cap[22], cap[23], cap[24]}, n[1][31:24]);
    end
  endtask

  task automatic test_flush();
    int bad;
    apply_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      new_golden_nonce = 1'b1;
      golden_nonce = n[i];
      step();
    end
    new_golden_nonce = 1'b0;
    checks++;
    if (fifo_count !== 3'd3 || tx_valid !== 1'b1 || tx_byte !== 8'hAA) begin
      errors++;
      $display("FAIL flush_setup: got cnt=%0d valid=%b byte=%h, want 3 1 aa",
               fifo_count, tx_valid, tx_byte);
    end
    tx_ready = 1'b1;
    step();
    step();
    checks++;
    if (tx_byte !== n[0][23:16]) begin
      errors++;
      $display("FAIL flush_b2: got %h, want %h", tx_byte, n[0][23:16]);
    end
    flush = 1'b1;
    new_golden_nonce = 1'b1;
    golden_nonce = 32'hBADBAD00;
    step();
    flush = 1'b0;
    new_golden_nonce = 1'b0;
    checks++;
    if (fifo_count !== 3'd0 || overflow !== 1'b0 || drop_count !== 8'd0 ||
        tx_valid !== 1'b1 || tx_byte !== n[0][15:8]) begin
      errors++;
      $display("FAIL flush_clear: got cnt=%0d ovf=%b drops=%0d valid=%b byte=%h, want 0 0 0 1 %h",
               fifo_count, overflow, drop_count, tx_valid, tx_byte, n[0][15:8]);
    end
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== n[0][7:0]) begin
      errors++;
      $display("FAIL flush_b0: got valid=%b byte=%h, want 1 %h", tx_valid, tx_byte, n[0][7:0]);
    end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (tx_valid !== 1'b0 || fifo_count !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL flush_idle: %0d cycles with valid or queued data, want 0", bad);
    end
  endtask

  task automatic test_saturation_reset();
    logic [7:0] exp [4];
    exp = '{8'h0B, 8'hAD, 8'hF0, 8'h0D};
    apply_reset();
    tx_ready = 1'b0;
    for (int i = 0; i < 305; i++) begin
      new_golden_nonce = 1'b1;
      golden_nonce = 32'(i);
      step();
    end
    new_golden_nonce = 1'b0;
    checks++;
    if (drop_count !== 8'd255 || overflow !== 1'b1 || fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL sat_drops: got drops=%0d ovf=%b cnt=%0d, want 255 1 4",
               drop_count, overflow, fifo_count);
    end
    tx_ready = 1'b1;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_valid, tx_byte, fifo_count, overflow, drop_count} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset: got valid=%b byte=%h cnt=%0d ovf=%b drops=%0d, want all 0",
               tx_valid, tx_byte, fifo_count, overflow, drop_count);
    end
    #1;
    reset = 1'b0;
    new_golden_nonce = 1'b1;
    golden_nonce = 32'h0BADF00D;
    step();
    new_golden_nonce = 1'b0;
    checks++;
    if (fifo_count !== 3'd1 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_push: got cnt=%0d valid=%b, want 1 0", fifo_count, tx_valid);
    end
    step();
    step();
    checks++;
    if (tx_valid !== 1'b1 || tx_byte !== 8'hAA) begin
      errors++;
      $display("FAIL post_reset_hdr: got valid=%b byte=%h, want 1 aa", tx_valid, tx_byte);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (tx_valid !== 1'b1 || tx_byte !== exp[i]) begin
        errors++;
        $display("FAIL post_reset_byte%0d: got valid=%b byte=%h, want 1 %h", i, tx_valid,
                 tx_byte, exp[i]);
      end
    end
    step();
    checks++;
    if (tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_end: got valid=%b, want 0", tx_valid);
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      n[i] = {8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), 8'(8'h40 + i)};
    end
    test_reset();
    test_single();
    test_backpressure();
    test_overflow();
    test_full_push_pop();
    test_flush();
    test_saturation_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
